// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, default widths and the micro-op record used by
//             the ALU operand stage and its operand mux.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 4;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_SHL  = 3'd4;
    localparam logic [2:0] ALU_SHR  = 3'd5;
    localparam logic [2:0] ALU_XOR  = 3'd6;
    localparam logic [2:0] ALU_ZERO = 3'd7;

    typedef struct packed {
        logic [2:0]           op;
        logic [DATA_W-1:0]    first;
        logic [DATA_W-1:0]    second;
        logic [REG_IDX_W-1:0] rd;
    } alu_uop_t;

endpackage

`default_nettype wire

// File: rtl/alu_operand_mux.sv
// ============================================================================
//  Module   : alu_operand_mux
//  Purpose  : Combinational operand builder: result forwarding, sign-extended
//             immediate select and shift-amount clamping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_mux #(
    parameter int IMM_W     = 8,
    parameter int SHAMT_MAX = 16
) (
    input  logic [2:0]                     op_i,
    input  logic [alu_pkg::REG_IDX_W-1:0]  rs1_idx_i,
    input  logic [alu_pkg::REG_IDX_W-1:0]  rs2_idx_i,
    input  logic [alu_pkg::DATA_W-1:0]     rs1_data_i,
    input  logic [alu_pkg::DATA_W-1:0]     rs2_data_i,
    input  logic [IMM_W-1:0]               imm_i,
    input  logic                           use_imm_i,
    input  logic [alu_pkg::REG_IDX_W-1:0]  rd_i,
    input  logic                           fwd_valid_i,
    input  logic [alu_pkg::REG_IDX_W-1:0]  fwd_rd_i,
    input  logic [alu_pkg::DATA_W-1:0]     fwd_data_i,
    output alu_pkg::alu_uop_t              uop_o
);
    import alu_pkg::*;

    localparam logic [DATA_W-1:0] SHAMT_CLAMP = DATA_W'(SHAMT_MAX);

    logic              fwd_rs1;
    logic              fwd_rs2;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] second_raw;
    logic              is_shift;

    // Register 0 is hardwired, so a write-back to it must never be forwarded.
    assign fwd_rs1 = fwd_valid_i && (fwd_rd_i == rs1_idx_i) && (rs1_idx_i != '0);
    assign fwd_rs2 = fwd_valid_i && (fwd_rd_i == rs2_idx_i) && (rs2_idx_i != '0);

    assign rs2_val    = fwd_rs2 ? fwd_data_i : rs2_data_i;
    assign imm_sext   = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign second_raw = use_imm_i ? imm_sext : rs2_val;
    assign is_shift   = (op_i == ALU_SHL) || (op_i == ALU_SHR);

    always_comb begin
        uop_o.op     = op_i;
        uop_o.first  = fwd_rs1 ? fwd_data_i : rs1_data_i;
        uop_o.second = (is_shift && (second_raw > SHAMT_CLAMP)) ? SHAMT_CLAMP : second_raw;
        uop_o.rd     = rd_i;
    end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : Registered operand stage ahead of the ALU with a 2-entry skid
//             buffer. Optional counters under ALU_OPERAND_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_stage #(
    parameter int DATA_W    = alu_pkg::DATA_W,
    parameter int IMM_W     = 8,
    parameter int REG_IDX_W = alu_pkg::REG_IDX_W,
    parameter int SHAMT_MAX = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [DATA_W-1:0]    in_rs1_data,
    input  logic [DATA_W-1:0]    in_rs2_data,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic                 in_use_imm,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 fwd_valid,
    input  logic [REG_IDX_W-1:0] fwd_rd,
    input  logic [DATA_W-1:0]    fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_first,
    output logic [DATA_W-1:0]    out_second,
    output logic [2:0]           out_alu_op,
    output logic [REG_IDX_W-1:0] out_rd
`ifdef ALU_OPERAND_STATS_EN
    ,
    output logic [15:0]          stat_issued,
    output logic [15:0]          stat_stall
`endif
);
    import alu_pkg::*;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    alu_uop_t   new_uop;
    alu_uop_t   main_q, main_d;
    alu_uop_t   skid_q, skid_d;
    logic [1:0] state_q, state_d;
    logic       in_ready_q;
    logic       accept;
    logic       xfer;

    alu_operand_mux #(
        .IMM_W     (IMM_W),
        .SHAMT_MAX (SHAMT_MAX)
    ) u_mux (
        .op_i        (in_op),
        .rs1_idx_i   (in_rs1_idx),
        .rs2_idx_i   (in_rs2_idx),
        .rs1_data_i  (in_rs1_data),
        .rs2_data_i  (in_rs2_data),
        .imm_i       (in_imm),
        .use_imm_i   (in_use_imm),
        .rd_i        (in_rd),
        .fwd_valid_i (fwd_valid),
        .fwd_rd_i    (fwd_rd),
        .fwd_data_i  (fwd_data),
        .uop_o       (new_uop)
    );

    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = new_uop;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && xfer) begin
                    main_d = new_uop;
                end else if (accept) begin
                    skid_d  = new_uop;
                    state_d = S_FULL;
                end else if (xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_first  = main_q.first;
    assign out_second = main_q.second;
    assign out_alu_op = main_q.op;
    assign out_rd     = main_q.rd;

`ifdef ALU_OPERAND_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_stall_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (xfer)
                stat_issued_q <= stat_issued_q + 16'd1;
            if (out_valid && !out_ready)
                stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Directed self-checking bench for alu_operand_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_rs1_idx;
    logic [3:0]  in_rs2_idx;
    logic [15:0] in_rs1_data;
    logic [15:0] in_rs2_data;
    logic [7:0]  in_imm;
    logic        in_use_imm;
    logic [3:0]  in_rd;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [15:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_first;
    logic [15:0] out_second;
    logic [2:0]  out_alu_op;
    logic [3:0]  out_rd;

    int n_checks = 0;
    int n_errors = 0;

    alu_operand_stage dut (
        .CLK         (clk),
        .Reset       (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1_idx  (in_rs1_idx),
        .in_rs2_idx  (in_rs2_idx),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .in_rd       (in_rd),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_first   (out_first),
        .out_second  (out_second),
        .out_alu_op  (out_alu_op),
        .out_rd      (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] i1, input logic [3:0] i2,
                         input logic [15:0] d1, input logic [15:0] d2,
                         input logic [7:0] imm, input logic use_imm, input logic [3:0] rd);
        in_valid    = 1'b1;
        in_op       = op;
        in_rs1_idx  = i1;
        in_rs2_idx  = i2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
        in_use_imm  = use_imm;
        in_rd       = rd;
    endtask

    // Single op through an otherwise idle stage with out_ready high.
    task automatic send_check(input string tag, input logic [2:0] op, input logic [3:0] i1,
                              input logic [3:0] i2, input logic [15:0] d1, input logic [15:0] d2,
                              input logic [7:0] imm, input logic use_imm,
                              input logic [15:0] exp_first, input logic [15:0] exp_second);
        drive(op, i1, i2, d1, d2, imm, use_imm, 4'd9);
        step();
        in_valid = 1'b0;
        check({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
        check({tag, ".first"},  {16'd0, out_first}, {16'd0, exp_first});
        check({tag, ".second"}, {16'd0, out_second}, {16'd0, exp_second});
        check({tag, ".op"},     {29'd0, out_alu_op}, {29'd0, op});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fwd_valid = 1'b0;
        fwd_rd    = 4'd0;
        fwd_data  = 16'd0;
        drive(3'd0, 4'd0, 4'd0, 16'd0, 16'd0, 8'd0, 1'b0, 4'd0);
        in_valid  = 1'b0;

        #12;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'd0, in_ready}, 32'd0);
        check("rst.first",     {16'd0, out_first}, 32'd0);
        check("rst.rd",        {28'd0, out_rd}, 32'd0);
        rst = 1'b0;
        step();
        check("rel.in_ready",  {31'd0, in_ready}, 32'd1);
        check("rel.out_valid", {31'd0, out_valid}, 32'd0);

        send_check("add",    3'd0, 4'd1, 4'd2, 16'h0003, 16'h0004, 8'h00, 1'b0, 16'h0003, 16'h0004);
        check("add.rd", {28'd0, out_rd}, 32'd9);
        send_check("immneg", 3'd0, 4'd1, 4'd2, 16'h0003, 16'h0004, 8'hF0, 1'b1, 16'h0003, 16'hFFF0);
        send_check("immpos", 3'd1, 4'd1, 4'd2, 16'h0003, 16'h0004, 8'h7F, 1'b1, 16'h0003, 16'h007F);

        fwd_valid = 1'b1;
        fwd_rd    = 4'd5;
        fwd_data  = 16'hBEEF;
        send_check("fwd",    3'd2, 4'd5, 4'd5, 16'h1111, 16'h2222, 8'h00, 1'b0, 16'hBEEF, 16'hBEEF);
        send_check("fwdimm", 3'd2, 4'd5, 4'd5, 16'h1111, 16'h2222, 8'h01, 1'b1, 16'hBEEF, 16'h0001);
        fwd_rd    = 4'd0;
        send_check("fwdr0",  3'd3, 4'd0, 4'd0, 16'h1111, 16'h2222, 8'h00, 1'b0, 16'h1111, 16'h2222);
        fwd_valid = 1'b0;
        fwd_rd    = 4'd5;
        send_check("nofwd",  3'd3, 4'd5, 4'd5, 16'h1111, 16'h2222, 8'h00, 1'b0, 16'h1111, 16'h2222);

        send_check("shl.clamp", 3'd4, 4'd1, 4'd2, 16'h0001, 16'h0025, 8'h00, 1'b0, 16'h0001, 16'h0010);
        send_check("shr.pass",  3'd5, 4'd1, 4'd2, 16'h0001, 16'h000F, 8'h00, 1'b0, 16'h0001, 16'h000F);
        send_check("shl.edge",  3'd4, 4'd1, 4'd2, 16'h0001, 16'h0010, 8'h00, 1'b0, 16'h0001, 16'h0010);
        send_check("shr.imm",   3'd5, 4'd1, 4'd2, 16'h0001, 16'h0000, 8'hFF, 1'b1, 16'h0001, 16'h0010);
        send_check("xor.noclamp", 3'd6, 4'd1, 4'd2, 16'h0001, 16'h0025, 8'h00, 1'b0, 16'h0001, 16'h0025);

        step();
        check("drain.out_valid", {31'd0, out_valid}, 32'd0);

        // Skid buffer: A, B accepted while stalled, C held off.
        out_ready = 1'b0;
        drive(3'd0, 4'd1, 4'd2, 16'h00AA, 16'h0001, 8'h00, 1'b0, 4'd1);
        step();
        check("fifo.A.in_ready", {31'd0, in_ready}, 32'd1);
        drive(3'd1, 4'd1, 4'd2, 16'h00BB, 16'h0002, 8'h00, 1'b0, 4'd2);
        step();
        check("fifo.full.in_ready", {31'd0, in_ready}, 32'd0);
        check("fifo.hold.A",        {16'd0, out_first}, 32'h00AA);
        drive(3'd2, 4'd1, 4'd2, 16'h00CC, 16'h0003, 8'h00, 1'b0, 4'd3);
        step();
        check("fifo.C.blocked",  {31'd0, in_ready}, 32'd0);
        check("fifo.hold.A2",    {16'd0, out_first}, 32'h00AA);
        check("fifo.hold.A.rd",  {28'd0, out_rd}, 32'd1);
        out_ready = 1'b1;
        step();
        check("fifo.B.first", {16'd0, out_first}, 32'h00BB);
        check("fifo.B.op",    {29'd0, out_alu_op}, 32'd1);
        check("fifo.B.ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("fifo.C.first", {16'd0, out_first}, 32'h00CC);
        check("fifo.C.valid", {31'd0, out_valid}, 32'd1);
        step();
        check("fifo.empty", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        drive(3'd0, 4'd1, 4'd2, 16'h0D01, 16'h0001, 8'h00, 1'b0, 4'd1);
        step();
        step();
        in_valid = 1'b0;
        check("pre.full", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", {31'd0, out_valid}, 32'd0);
        check("arst.in_ready",  {31'd0, in_ready}, 32'd0);
        check("arst.first",     {16'd0, out_first}, 32'd0);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("post.in_ready",  {31'd0, in_ready}, 32'd1);
        check("post.out_valid", {31'd0, out_valid}, 32'd0);
        send_check("post.D", 3'd3, 4'd1, 4'd2, 16'h0D0D, 16'h0E0E, 8'h00, 1'b0, 16'h0D0D, 16'h0E0E);
        step();
        check("post.drain", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the 16-bit ALU.
- Accepts decoded micro-ops and builds the ALU first/second operands: register vs. sign-extended immediate select, one-deep result forwarding, and shift-amount clamping.
- Presents registered operands plus the 3-bit ALU opcode through a valid/ready interface.
- Uses a 2-entry skid buffer so that in_ready is purely registered.

Parameters:
- DATA_W, 16, operand/result width.
- IMM_W, 8, immediate field width; sign-extended to DATA_W.
- REG_IDX_W, 4, register index width.
- SHAMT_MAX, 16, clamp value for the shift second operand.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  micro-op present.
- in_ready  out  1  stage can accept a micro-op this cycle.
- in_op  in  3  ALU opcode (0 add, 1 sub, 2 or, 3 and, 4 shl, 5 shr, 6 xor, 7 zero).
- in_rs1_idx  in  REG_IDX_W  source-1 register index.
- in_rs2_idx  in  REG_IDX_W  source-2 register index.
- in_rs1_data  in  DATA_W  register-file value for rs1.
- in_rs2_data  in  DATA_W  register-file value for rs2.
- in_imm  in  IMM_W  immediate field.
- in_use_imm  in  1  second operand = sext(in_imm) instead of rs2.
- in_rd  in  REG_IDX_W  destination index, passed through.
- fwd_valid  in  1  ALU result being written back this cycle.
- fwd_rd  in  REG_IDX_W  destination of the forwarded result.
- fwd_data  in  DATA_W  forwarded ALU result.
- out_valid  out  1  operands valid.
- out_ready  in  1  ALU consumes operands this cycle.
- out_first  out  DATA_W  ALU first operand.
- out_second  out  DATA_W  ALU second operand.
- out_alu_op  out  3  opcode to the ALU.
- out_rd  out  REG_IDX_W  destination index.

Behaviour:
- Reset (async, active-high): out_valid=0, in_ready=0 while Reset is asserted and 1 the first cycle after release. out_first, out_second, out_alu_op and out_rd are all 0. Both buffer entries are invalid.
- Reset mid-operation drops all buffered ops; no partial output.
- Accept: in_valid && in_ready on a rising edge. Transfer: out_valid && out_ready.
- Operand build happens combinationally at accept time; the result is captured into a register.
  - first = (fwd_valid && fwd_rd==in_rs1_idx && in_rs1_idx!=0) ? fwd_data : in_rs1_data.
  - second_raw = in_use_imm ? sext(in_imm) : (same forwarding rule on rs2).
  - For op 4/5: second = (second_raw unsigned > SHAMT_MAX) ? SHAMT_MAX : second_raw.
  - For all other ops: second = second_raw.
  - Register 0 is never forwarded.
- Latency: accept at edge N gives out_valid=1 after edge N; the ALU may consume in the same cycle. Throughput is 1 op/cycle when out_ready=1.
- Buffer state machine (main = output register, skid = overflow):
  - EMPTY: accept -> ONE.
  - ONE: transfer without accept -> EMPTY; accept without transfer -> FULL (op goes to skid); accept and transfer -> ONE (new op to main).
  - FULL: transfer -> ONE (skid moves to main; no accept possible).
- in_ready = (state != FULL), registered. Order is strictly FIFO.
- Outputs are held stable while out_valid && !out_ready.
- Forwarding is sampled only at accept; ops already buffered are not re-forwarded. The upstream stage stalls on such a hazard.
- in_valid without in_ready: the input is ignored and upstream holds it.

Optional Feature:
- ALU_OPERAND_STATS_EN: adds outputs stat_issued[15:0] and stat_stall[15:0].
  - stat_issued counts transfers; stat_stall counts cycles with out_valid && !out_ready.
  - Both counters wrap at 0xFFFF->0 and reset to 0.
- Without the macro, neither the ports nor the counters exist.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants ALU_ADD..ALU_ZERO (3-bit);
  - DATA_W and REG_IDX_W defaults;
  - a packed struct alu_uop_t {op, first, second, rd}, used for both buffer entries.
- One natural sub-module: alu_operand_mux, the combinational forward/immediate/clamp logic, instantiated once at the input.

Test Plan:
- Reset release, then in_op=0, rs1=0x0003, rs2=0x0004, use_imm=0, out_ready=1 -> next cycle out_valid=1, first=0x0003, second=0x0004, op=0.
- use_imm=1, imm=0xF0 -> second=0xFFF0; imm=0x7F -> second=0x007F.
- fwd_valid=1, fwd_rd=5, fwd_data=0xBEEF, rs1_idx=5, rs2_idx=5 -> first=second=0xBEEF. Repeat with idx=0 and fwd_rd=0 -> register-file values are used.
- op=4, rs2=0x0025 -> second=0x0010; op=5, rs2=0x000F -> second=0x000F.
- Hold out_ready=0 and push 3 ops A,B,C -> A,B accepted, in_ready=0 for C. Raise out_ready -> outputs A,B,C in order, no loss or duplication.
- Assert Reset asynchronously mid-FULL -> out_valid=0 immediately; after release the first accepted op is output with nothing stale before it.
